// File: rtl/lif_scheduler.sv
`timescale 1ns/1ps
// Leaky integrate-and-fire scheduler: N_NEUR neurons share one update datapath,
// each swept through FETCH / COMPUTE / WRITEBACK once per tick.
module lif_scheduler #(
    parameter int unsigned N_NEUR  = 4,
    parameter int unsigned REFRACT = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick,
    input  logic [N_NEUR*8-1:0]   current,
    input  logic [7:0]            thresh,
    input  logic [1:0]            leak_shift,
    input  logic [2:0]            mon_sel,
    output logic                  busy,
    output logic                  done,
    output logic [N_NEUR-1:0]     spike,
    output logic [7:0]            mon_state,
    output logic                  overrun
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StCompute,
        StWriteback
    } state_e;

    localparam logic [2:0] LastIdx    = 3'(N_NEUR - 1);
    localparam logic [2:0] RefractVal = 3'(REFRACT);

    state_e              state_q, state_d;
    logic [2:0]          idx_q, idx_d;

    logic [7:0]          v_q [N_NEUR];
    logic [2:0]          r_q [N_NEUR];
    logic [N_NEUR-1:0]   spike_q;
    logic                done_q;
    logic                overrun_q;

    // Sweep-wide copies of the control inputs
    logic [7:0]          thresh_q;
    logic [1:0]          lshift_q;

    // Operands captured in FETCH
    logic [7:0]          fv_q;
    logic [2:0]          fr_q;
    logic [7:0]          fi_q;

    // Results registered in COMPUTE
    logic [7:0]          nv_q;
    logic [2:0]          nr_q;
    logic                ns_q;

    logic [7:0]          sel_v;
    logic [2:0]          sel_r;
    logic [7:0]          sel_i;

    logic [7:0]          vl;
    logic [8:0]          sum9;
    logic [7:0]          sum_sat;
    logic [7:0]          th_eff;
    logic [7:0]          cv_v;
    logic [2:0]          cv_r;
    logic                cv_s;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (tick) begin
                    state_d = StFetch;
                    idx_d   = '0;
                end
            end
            StFetch:   state_d = StCompute;
            StCompute: state_d = StWriteback;
            StWriteback: begin
                if (idx_q == LastIdx) begin
                    state_d = StIdle;
                    idx_d   = '0;
                end else begin
                    state_d = StFetch;
                    idx_d   = idx_q + 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------- operand muxes
    always_comb begin
        sel_v = '0;
        sel_r = '0;
        sel_i = '0;
        for (int i = 0; i < int'(N_NEUR); i++) begin
            if (idx_q == 3'(i)) begin
                sel_v = v_q[i];
                sel_r = r_q[i];
                sel_i = current[i*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------- neuron update
    always_comb begin
        vl      = fv_q - (fv_q >> lshift_q);
        sum9    = {1'b0, vl} + {1'b0, fi_q};
        sum_sat = sum9[8] ? 8'hFF : sum9[7:0];
        // A zero threshold behaves as 1 so a silent neuron never fires
        th_eff  = (thresh_q == 8'd0) ? 8'd1 : thresh_q;
        cv_v    = '0;
        cv_r    = '0;
        cv_s    = 1'b0;
        if (fr_q != 3'd0) begin
            cv_r = fr_q - 3'd1;
        end else if (sum_sat >= th_eff) begin
            cv_r = RefractVal;
            cv_s = 1'b1;
        end else begin
            cv_v = sum_sat;
        end
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N_NEUR); i++) begin
                v_q[i] <= '0;
                r_q[i] <= '0;
            end
            spike_q   <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            thresh_q  <= '0;
            lshift_q  <= '0;
            fv_q      <= '0;
            fr_q      <= '0;
            fi_q      <= '0;
            nv_q      <= '0;
            nr_q      <= '0;
            ns_q      <= 1'b0;
        end else begin
            done_q <= (state_q == StWriteback) && (idx_q == LastIdx);
            if (tick && (state_q != StIdle)) begin
                overrun_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (tick) begin
                        spike_q  <= '0;
                        thresh_q <= thresh;
                        lshift_q <= leak_shift;
                    end
                end
                StFetch: begin
                    fv_q <= sel_v;
                    fr_q <= sel_r;
                    fi_q <= sel_i;
                end
                StCompute: begin
                    nv_q <= cv_v;
                    nr_q <= cv_r;
                    ns_q <= cv_s;
                end
                StWriteback: begin
                    for (int i = 0; i < int'(N_NEUR); i++) begin
                        if (idx_q == 3'(i)) begin
                            v_q[i]     <= nv_q;
                            r_q[i]     <= nr_q;
                            spike_q[i] <= ns_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------- outputs
    always_comb begin
        mon_state = '0;
        for (int i = 0; i < int'(N_NEUR); i++) begin
            if (mon_sel == 3'(i)) begin
                mon_state = v_q[i];
            end
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign spike   = spike_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_lif_scheduler.sv
`timescale 1ns/1ps
// Scoreboard bench for lif_scheduler: stimulus pushes expected sweep results,
// a monitor pops and compares them on every done pulse.
module tb_lif_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick = 1'b0;
    logic [31:0] current = '0;
    logic [7:0]  thresh = 8'd200;
    logic [1:0]  leak_shift = 2'd1;
    logic [2:0]  mon_sel;
    logic        busy;
    logic        done;
    logic [3:0]  spike;
    logic [7:0]  mon_state;
    logic        overrun;

    lif_scheduler #(
        .N_NEUR  (4),
        .REFRACT (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .current    (current),
        .thresh     (thresh),
        .leak_shift (leak_shift),
        .mon_sel    (mon_sel),
        .busy       (busy),
        .done       (done),
        .spike      (spike),
        .mon_state  (mon_state),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  spk;
        logic [31:0] v;   // {v3, v2, v1, v0}
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    endtask

    task automatic push(input logic [3:0] spk, input logic [31:0] v);
        exp_t e;
        e.spk = spk;
        e.v   = v;
        exp_q.push_back(e);
    endtask

    task automatic start_sweep();
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic sweep(input string name);
        start_sweep();
        wait_done(name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // ------------------------------------------------------------- monitor
    initial begin : monitor
        int   busy_cnt;
        exp_t e;
        busy_cnt = 0;
        mon_sel  = 3'd2;
        forever begin
            @(negedge clk);
            if (rst) busy_cnt = 0;
            else if (busy) busy_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("spike", {28'd0, spike}, {28'd0, e.spk});
                    for (int i = 0; i < 4; i++) begin
                        mon_sel = 3'(i);
                        #1;
                        check($sformatf("v%0d", i), {24'd0, mon_state}, {24'd0, e.v[i*8 +: 8]});
                    end
                    mon_sel = 3'd2;
                    check("busy_cycles", 32'(busy_cnt), 32'd12);
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ------------------------------------------------------------ stimulus
    initial begin : stimulus
        logic [7:0] t2_v0  [6];
        logic       t2_spk [6];
        t2_v0  = '{8'd128, 8'd192, 8'd0, 8'd0, 8'd0, 8'd128};
        t2_spk = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_spike", {28'd0, spike}, 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_mon", {24'd0, mon_state}, 32'd0);
        rst = 1'b0;

        // All-zero currents
        push(4'b0000, 32'h0);
        sweep("t1");

        // Neuron 0 integrates, fires, goes refractory
        current = 32'h0000_0080;
        for (int k = 0; k < 6; k++) begin
            push({3'b000, t2_spk[k]}, {24'd0, t2_v0[k]});
            sweep($sformatf("t2_s%0d", k));
        end

        // Saturation on neuron 1
        do_reset();
        current    = 32'h0000_C800;
        thresh     = 8'd255;
        leak_shift = 2'd3;
        push(4'b0000, 32'h0000_C800);
        sweep("t3_s0");
        push(4'b0010, 32'h0);
        sweep("t3_s1");

        // Overrun and back-to-back sweeps
        do_reset();
        check("t4_overrun_clr", 32'(overrun), 32'd0);
        current    = 32'h000A_0000;
        thresh     = 8'd200;
        leak_shift = 2'd1;
        push(4'b0000, 32'h000A_0000);
        start_sweep();
        repeat (4) @(posedge clk);
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        check("t4_overrun_set", 32'(overrun), 32'd1);
        wait_done("t4_a");
        repeat (3) @(negedge clk);
        check("t4_no_extra", 32'(busy), 32'd0);
        check("t4_overrun_sticky", 32'(overrun), 32'd1);
        push(4'b0000, 32'h000F_0000);
        sweep("t4_b");
        push(4'b0000, 32'h0012_0000);
        tick = 1'b1;
        @(posedge clk);
        #1 tick = 1'b0;
        check("t4_b2b_start", 32'(busy), 32'd1);
        wait_done("t4_c");
        check("t4_overrun_hold", 32'(overrun), 32'd1);

        // Reset during COMPUTE of neuron 2
        current = 32'h3232_3232;
        start_sweep();
        repeat (7) @(posedge clk);
        #1;
        check("t5_pre_v2", {24'd0, mon_state}, 32'h12);
        #1 rst = 1'b1;
        #1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_spike", {28'd0, spike}, 32'd0);
        check("t5_overrun", 32'(overrun), 32'd0);
        check("t5_v2", {24'd0, mon_state}, 32'd0);
        @(negedge clk);
        tick = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_tick_in_rst", 32'(busy), 32'd0);
        check("t5_tick_in_rst_ovr", 32'(overrun), 32'd0);
        push(4'b0000, 32'h3232_3232);
        rst = 1'b0;
        @(posedge clk);
        #1 tick = 1'b0;
        check("t5_first_tick", 32'(busy), 32'd1);
        wait_done("t5");

        // Zero threshold, then a mid-sweep threshold change
        do_reset();
        current    = 32'h0101_0101;
        thresh     = 8'd0;
        leak_shift = 2'd1;
        push(4'b1111, 32'h0);
        sweep("t6_s0");
        push(4'b0000, 32'h0);
        start_sweep();
        check("t6_spike_clr", {28'd0, spike}, 32'd0);
        wait_done("t6_s1");
        push(4'b0000, 32'h0);
        sweep("t6_s2");
        push(4'b1111, 32'h0);
        start_sweep();
        repeat (4) @(posedge clk);
        #1 thresh = 8'd255;
        wait_done("t6_s3");
        push(4'b0000, 32'h0);
        sweep("t6_s4");
        push(4'b0000, 32'h0);
        sweep("t6_s5");
        push(4'b0000, 32'h0101_0101);
        sweep("t6_s6");

        repeat (5) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lif_scheduler.md
LIF_SCHEDULER -- requirements
Module: lif_scheduler

Interface
REQ-001 The block SHALL have parameter N_NEUR, default 4, giving the number of neurons time-multiplexed onto one update datapath; legal values are 2..8.
REQ-002 The block SHALL have parameter REFRACT, default 2, giving the number of sweeps a neuron is held after a spike; legal values are 0..7.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port tick, input, 1 bit: request for one sweep (update of every neuron once).
REQ-006 The block SHALL have port current, input, N_NEUR*8 bits: unsigned input current per neuron; slice [8i+7:8i] belongs to neuron i.
REQ-007 The block SHALL have port thresh, input, 8 bits: firing threshold.
REQ-008 The block SHALL have port leak_shift, input, 2 bits: leak shift amount.
REQ-009 The block SHALL have port mon_sel, input, 3 bits: neuron index shown on mon_state.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse at sweep end.
REQ-012 The block SHALL have port spike, output, N_NEUR bits: per-neuron spike result of the most recent sweep.
REQ-013 The block SHALL have port mon_state, output, 8 bits: membrane value of neuron mon_sel.
REQ-014 The block SHALL have port overrun, output, 1 bit: sticky flag; set by a tick that arrives while busy.

Function
REQ-015 The block SHALL keep, per neuron, an 8-bit membrane register v[i] and a 3-bit refractory counter r[i].
REQ-016 The FSM SHALL have states IDLE, FETCH, COMPUTE and WRITEBACK, plus a neuron index idx.
REQ-017 tick SHALL be sampled only in IDLE; tick=1 there moves the FSM to FETCH with idx=0, clears spike to 0, and latches thresh and leak_shift for the whole sweep.
REQ-018 FETCH SHALL capture v[idx], r[idx] and current slice idx; COMPUTE SHALL produce the next values; WRITEBACK SHALL write v[idx], r[idx] and spike[idx].
REQ-019 After WRITEBACK the FSM SHALL go to FETCH with idx+1 if idx<N_NEUR-1, otherwise to IDLE.
REQ-020 Each neuron SHALL take 3 cycles, so a sweep takes 3*N_NEUR cycles (12 at default); busy SHALL be 1 exactly when the FSM is not in IDLE.
REQ-021 done SHALL be registered and high for exactly the one cycle in which the FSM has just returned to IDLE.
REQ-022 A tick sampled in IDLE on the same edge that done is high SHALL start a new sweep; back-to-back sweeps are legal.
REQ-023 A tick while busy=1 SHALL be ignored (not queued) and SHALL set overrun to 1; overrun clears only on rst.
REQ-024 Leak SHALL be computed as vl = v - (v >> leak_shift), unsigned; leak_shift=0 gives vl=0 (full leak).
REQ-025 The sum SHALL be s = vl + I, computed at 9 bits and saturated to 255.
REQ-026 If r>0: v'=0, r'=r-1, spike=0, and the current is ignored.
REQ-027 Else if s >= max(thresh,1): v'=0, r'=REFRACT, spike=1.
REQ-028 Otherwise: v'=s, r'=0, spike=0.
REQ-029 spike bits SHALL hold from their WRITEBACK until the next sweep start, and SHALL be stable and valid whenever done=1.
REQ-030 mon_state SHALL be combinational v[mon_sel]; it reads 0 when mon_sel >= N_NEUR.
REQ-031 Changes on current, thresh or leak_shift during a sweep SHALL NOT affect neurons already fetched; current is sampled per neuron in its FETCH.

Reset
REQ-032 rst=1 SHALL asynchronously force the FSM to IDLE, idx=0, all v and r to 0, spike=0, busy=0, done=0 and overrun=0, including mid-sweep; a partially completed sweep is discarded with no done pulse.
REQ-033 Ticks SHALL be ignored while rst=1; the first tick accepted is the one sampled on the first rising edge after rst deasserts.

Verification
REQ-034 The bench SHALL cover: one tick after reset, with all currents 0 -> busy high 12 cycles, done pulse on cycle 13, spike=0000, all v=0.
REQ-035 The bench SHALL cover: neuron0 I=128, thresh=200, leak_shift=1, REFRACT=2, six sweeps -> v0 = 128, 192, 0 (spike0=1 in sweep 3), 0, 0 (refractory), 128.
REQ-036 The bench SHALL cover saturation: neuron1 I=200, thresh=255, leak_shift=3 -> sweep 1 v1=200 with no spike; sweep 2 has 175+200 saturate to 255, giving spike1=1 and v1=0.
REQ-037 The bench SHALL cover: tick pulsed at cycle 5 of a sweep -> no extra sweep, overrun=1 and it stays 1; a tick on the done cycle starts an immediate next sweep.
REQ-038 The bench SHALL cover: rst asserted during the COMPUTE of neuron 2 -> outputs immediately at reset values, no done pulse; after release one tick gives a normal 12-cycle sweep.
REQ-039 The bench SHALL cover: thresh=0 with I=1 -> every non-refractory neuron spikes every sweep; changing thresh mid-sweep has no effect until the next sweep.
